// File: rtl/risc_cpu.sv
// Multicycle 16-bit RISC core: IR, decoder, FSM controller and datapath
// (8x16 register file, A/B/C regs, shifter, ALU, N/V/Z status).
//
// state    | meaning
// S_WAIT   | idle, w=1, waits for s
// S_DECODE | pick path from IR op/sub
// S_WIMM   | Rn <= sximm8
// S_GETA   | A <= R[Rn]
// S_GETB   | B <= R[Rm]
// S_COMP   | C <= ALU result, CMP loads status
// S_WREG   | R[Rd] <= C
module risc_cpu #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s,
  input  logic                  load,
  input  logic [data_width-1:0] in,
  input  logic [data_width-1:0] mdata,
  input  logic [7:0]            PC,
  output logic [data_width-1:0] out,
  output logic                  N,
  output logic                  V,
  output logic                  Z,
  output logic                  w
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_COMP, S_WREG
  } state_t;

  state_t                state;
  logic [data_width-1:0] ir, a, b, c;
  logic [data_width-1:0] rf [0:7];

  logic [2:0] op, rn, rd, rm;
  logic [1:0] sub, sh;
  logic [data_width-1:0] sximm8, sximm5;

  assign op     = ir[15:13];
  assign sub    = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(data_width-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(data_width-5){ir[4]}}, ir[4:0]};

  logic is_movimm, is_movreg, is_alu, is_mvn, is_cmp;
  assign is_movimm = (op == 3'b110) && (sub == 2'b10);
  assign is_movreg = (op == 3'b110) && (sub == 2'b00);
  assign is_alu    = (op == 3'b101);
  assign is_mvn    = is_alu && (sub == 2'b11);
  assign is_cmp    = is_alu && (sub == 2'b01);

  logic asel, bsel;
  assign asel = is_movreg || is_mvn;
  assign bsel = 1'b0;

  logic [data_width-1:0] shout, ain, bin, alu_res;

  always_comb begin
    case (sh)
      2'b01:   shout = {b[data_width-2:0], 1'b0};
      2'b10:   shout = {1'b0, b[data_width-1:1]};
      2'b11:   shout = {b[data_width-1], b[data_width-1:1]};
      default: shout = b;
    endcase
  end

  assign ain = asel ? '0 : a;
  assign bin = bsel ? sximm5 : shout;

  always_comb begin
    case (sub)
      2'b00:   alu_res = ain + bin;
      2'b01:   alu_res = ain - bin;
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // Overflow of A-B: operands differ in sign and result sign differs from A.
  logic sub_ovf;
  assign sub_ovf = (ain[data_width-1] != bin[data_width-1]) &&
                   (alu_res[data_width-1] != ain[data_width-1]);

  logic [1:0]            vsel;
  logic [data_width-1:0] wdata;
  logic                  we;
  logic [2:0]            wnum;

  assign vsel = (state == S_WIMM) ? 2'b01 : 2'b11;
  assign we   = (state == S_WIMM) || (state == S_WREG);
  assign wnum = (state == S_WIMM) ? rn : rd;

  always_comb begin
    case (vsel)
      2'b00:   wdata = mdata;
      2'b01:   wdata = sximm8;
      2'b10:   wdata = {{(data_width-8){1'b0}}, PC};
      default: wdata = c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      N     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (load) ir <= in;
      if (we) rf[wnum] <= wdata;
      case (state)
        S_WAIT:   if (s) state <= S_DECODE;
        S_DECODE: begin
          if (is_movimm)                 state <= S_WIMM;
          else if (is_movreg || is_mvn)  state <= S_GETB;
          else if (is_alu)               state <= S_GETA;
          else                           state <= S_WAIT;
        end
        S_WIMM:   state <= S_WAIT;
        S_GETA: begin
          a     <= rf[rn];
          state <= S_GETB;
        end
        S_GETB: begin
          b     <= rf[rm];
          state <= S_COMP;
        end
        S_COMP: begin
          c <= alu_res;
          if (is_cmp) begin
            Z     <= (alu_res == '0);
            N     <= alu_res[data_width-1];
            V     <= sub_ovf;
            state <= S_WAIT;
          end else begin
            state <= S_WREG;
          end
        end
        S_WREG:   state <= S_WAIT;
        default:  state <= S_WAIT;
      endcase
    end
  end

  assign out = c;
  assign w   = (state == S_WAIT);

endmodule

// File: tb/tb_risc_cpu.sv
// Directed test of risc_cpu: instruction sequences with hand-computed results,
// cycle counts, status flags, shifter edge cases and mid-instruction reset.
module tb_risc_cpu;
  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in, mdata, out;
  logic [7:0]  PC;
  logic        N, V, Z, w;

  int total = 0;
  int fails = 0;

  risc_cpu dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .mdata(mdata),
    .PC(PC), .out(out), .N(N), .V(V), .Z(Z), .w(w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic [2:0] exp_nvz);
    chk({tag, " NVZ"}, {13'b0, N, V, Z}, {13'b0, exp_nvz});
  endtask

  task automatic run(input logic [15:0] instr, input int exp_cyc, input string tag);
    int n;
    @(negedge clk);
    in = instr; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0; n = 1;
    while (!w && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " cycles"}, 16'(n), 16'(exp_cyc));
  endtask

  task automatic readreg(input logic [2:0] r, input logic [15:0] exp, input string tag);
    run({8'hC0, r, 2'b00, r}, 5, tag);
    chk(tag, out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    mdata = 16'h1234; PC = 8'h56;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset w", {15'b0, w}, 16'h0001);
    chk("reset out", out, 16'h0000);
    chkf("reset", 3'b000);

    run(16'hD007, 3, "mov r0 #7");
    readreg(3'd0, 16'h0007, "r0");
    run(16'hD102, 3, "mov r1 #2");
    run(16'hA148, 6, "add r2");
    chk("add r2 out", out, 16'h0010);
    chkf("add r2", 3'b000);
    readreg(3'd2, 16'h0010, "r2");
    run(16'hC042, 5, "mov r2 r2");
    chk("mov r2 r2 out", out, 16'h0010);
    run(16'hD3FF, 3, "mov r3 #-1");
    readreg(3'd3, 16'hFFFF, "r3 sext");

    run(16'hA902, 5, "cmp r1 r2");
    chk("cmp r1 r2 out", out, 16'hFFF2);
    chkf("cmp r1 r2", 3'b100);
    run(16'hAA01, 5, "cmp r2 r1");
    chk("cmp r2 r1 out", out, 16'h000E);
    chkf("cmp r2 r1", 3'b000);

    run(16'hB201, 6, "and r0");
    chk("and r0 out", out, 16'h0000);
    chkf("and keeps flags", 3'b000);
    run(16'hB800, 5, "mvn r0");
    chk("mvn r0 out", out, 16'hFFFF);
    readreg(3'd0, 16'hFFFF, "r0 after mvn");

    run(16'hD4FF, 3, "mov r4 #-1");
    run(16'hC094, 5, "mov r4 lsr");
    chk("lsr ffff", out, 16'h7FFF);
    run(16'hAC03, 5, "cmp ovf");
    chk("cmp ovf out", out, 16'h8000);
    chkf("cmp ovf", 3'b110);
    run(16'hA901, 5, "cmp r1 r1");
    chk("cmp eq out", out, 16'h0000);
    chkf("cmp eq", 3'b001);

    run(16'hB8A4, 5, "mvn r5 r4");
    chk("mvn 7fff", out, 16'h8000);
    chkf("mvn keeps flags", 3'b001);
    run(16'hC0D5, 5, "lsr 8000");
    chk("lsr 8000", out, 16'h4000);
    run(16'hC0DD, 5, "asr 8000");
    chk("asr 8000", out, 16'hC000);
    run(16'hC0CD, 5, "lsl 8000");
    chk("lsl 8000", out, 16'h0000);

    run(16'hA3E3, 6, "add wrap");
    chk("add wrap out", out, 16'hFFFE);
    chkf("add keeps flags", 3'b001);
    readreg(3'd7, 16'hFFFE, "r7");

    run(16'h0000, 2, "illegal op000");
    run(16'hE123, 2, "illegal op111");
    run(16'hC800, 2, "illegal mov sub01");
    chk("illegal out", out, 16'hFFFE);
    chkf("illegal flags", 3'b001);
    readreg(3'd0, 16'hFFFF, "r0 after illegal");

    // Abort an ADD R0,R1,R1 mid-flight; nothing may be written back.
    @(negedge clk);
    in = 16'hA101; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    @(negedge clk);
    reset = 1'b1; load = 1'b1; s = 1'b1; in = 16'hD0AA;
    @(negedge clk);
    reset = 1'b0; load = 1'b0; s = 1'b0;
    chk("abort w", {15'b0, w}, 16'h0001);
    chk("abort out", out, 16'h0000);
    chkf("abort", 3'b000);
    readreg(3'd1, 16'h0000, "r1 cleared");
    readreg(3'd0, 16'h0000, "r0 cleared");
    readreg(3'd7, 16'h0000, "r7 cleared");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
